debug_cmd_arbiter: RTL and testbench
====================================

Name: debug_cmd_arbiter

Overview:
- Shares the single byte-wide debug command/response channel of the debug interface between NUM_REQ requesters (e.g. UART bridge, USB control endpoint, on-chip script engine).
- Arbitrates requests, issues one command at a time and frames the response byte stream, including a last flag.
- Routes the response back to the winning requester and converts a silent interface into a timeout error byte.
- Sits between the requester bridges and debug_interface in the usb_proxy hierarchy.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- TIMEOUT, 16, cycles to wait for the first response byte after command issue.
- MAX_RESP_LEN, 16, maximum bytes forwarded per response.
- GAP_CYCLES, 2, idle cycles enforced after a response before the next issue.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Synchronous, active-low.
- req_cmd  in  NUM_REQ*8  command byte per requester; requester i uses bits [8i+7:8i].
- req_cmd_valid  in  NUM_REQ  per-requester command valid.
- req_cmd_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- req_resp_data  out  8  response byte, shared by all requesters.
- req_resp_valid  out  NUM_REQ  one-hot valid addressing the owning requester.
- req_resp_last  out  1  marks the final byte of a response.
- debug_cmd  out  8  command to debug_interface.
- debug_cmd_valid  out  1  one-cycle command strobe.
- debug_resp  in  8  response byte from debug_interface.
- debug_resp_valid  in  1  response byte valid.
- busy  out  1  high in every state except IDLE.
- grant_id  out  2  index of current or last granted requester.
- timeout_count  out  8  saturating count of timed-out commands.

Behaviour:
- Reset values: state=IDLE; all outputs 0; rr_ptr=NUM_REQ-1, so requester 0 wins first; held byte cleared.
- Reset mid-operation: return to IDLE immediately; no req_resp_last is emitted and no partial response is delivered.
- IDLE, when any req_cmd_valid is set:
  - Select the first valid index searching from rr_ptr+1, wrapping modulo NUM_REQ.
  - Pulse req_cmd_ready[win] for one cycle and latch req_cmd[win].
  - Set grant_id=win and rr_ptr=win, then go to ISSUE.
- A requester keeps its valid asserted until it sees ready. Ready never asserts outside IDLE.
- ISSUE: drive debug_cmd=latched byte and debug_cmd_valid=1 for exactly one cycle. Clear the timer, go to WAIT_FIRST.
- WAIT_FIRST:
  - When debug_resp_valid=1: capture the byte into the hold register, set len=1, go to STREAM.
  - Otherwise increment the timer.
  - When timer==TIMEOUT-1: output req_resp_data=8'hFE with valid[grant] and last=1 for one cycle, increment timeout_count (saturating at 8'hFF), go to GAP.
- STREAM forwards the response with one cycle of latency through the hold register. Each cycle:
  - If debug_resp_valid=1 and len<MAX_RESP_LEN: output the held byte with last=0, capture the new byte, len++.
  - If debug_resp_valid=1 and len==MAX_RESP_LEN: output the held byte with last=1 and go to DRAIN (truncation).
  - If debug_resp_valid=0: output the held byte with last=1 and go to GAP.
- DRAIN: discard incoming bytes, with no req_resp_valid. Go to GAP on the first cycle with debug_resp_valid=0.
- GAP: count GAP_CYCLES idle cycles, then go to IDLE. This guarantees the interface has cleared its sending flag before the next command.
- debug_resp_valid while in IDLE, ISSUE or GAP: ignored and not forwarded.
- Requests arriving during any non-IDLE state are not lost. They are served in later arbitration rounds.
- Exactly one bit of req_resp_valid is high in any cycle, and only for the granted requester.
- len counter width is clog2(MAX_RESP_LEN)+1 bits. The timer counts 0..TIMEOUT-1 and does not wrap.

Optional Feature:
DEBUG_ARB_FIXED_PRIO_EN:
- Defined: requester 0 always wins when its valid is set; the remaining requesters are round-robin among themselves. rr_ptr does not advance on a requester-0 grant.
- Undefined: plain round-robin across all requesters as described above.

Test Plan:
- Req0 sends 8'hF0; interface returns F0,01,00,00 on consecutive cycles → req_resp_valid=01 for 4 bytes F0,01,00,00; last only on 00 (4th byte); busy low after GAP.
- Req0 and req1 both valid in the same cycle after reset → req0 granted first, req1 granted on the next IDLE; grant_id 0 then 1; the second debug_cmd_valid is at least GAP_CYCLES+2 cycles after the first response's last byte.
- Command with the interface stubbed silent → after 16 cycles a single byte 8'hFE with last=1 to the requester; timeout_count=1; 256 timeouts leave timeout_count=8'hFF.
- Stub returns 20 back-to-back bytes 00..13 with MAX_RESP_LEN=16 → 16 bytes 00..0F forwarded, last on 0F, bytes 10..13 dropped, arbiter returns to IDLE.
- Assert rst_n=0 for one cycle during STREAM after 2 bytes → no further req_resp_valid, busy=0 the next cycle; the following command is processed normally.
- With DEBUG_ARB_FIXED_PRIO_EN and req0 held continuously valid alongside req1 → req0 granted every round; with the macro undefined → grants alternate 0,1,0,1.

Source files
------------

// File: rtl/debug_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// debug_cmd_arbiter
//
// Shares the single byte-wide command/response channel of debug_interface
// between NUM_REQ requester bridges. One command is in flight at a time. The
// response stream is framed with a last flag and routed back to the owning
// requester. A silent interface is turned into a single 8'hFE error byte.
//
// Optional build macro:
//   DEBUG_ARB_FIXED_PRIO_EN - requester 0 always wins when valid; the others
//                             round-robin among themselves. When the macro is
//                             undefined, plain round-robin runs over all
//                             requesters.
//
// Ports:
//   clk              system clock
//   rst_n            synchronous active-low reset
//   req_cmd          NUM_REQ command bytes, requester i on [8i+7:8i]
//   req_cmd_valid    per-requester command valid
//   req_cmd_ready    one-hot accept pulse (only in IDLE)
//   req_resp_data    shared response byte
//   req_resp_valid   one-hot valid addressing the owning requester
//   req_resp_last    final byte of a response
//   debug_cmd        command byte to debug_interface
//   debug_cmd_valid  one-cycle command strobe
//   debug_resp       response byte from debug_interface
//   debug_resp_valid response byte valid
//   busy             high in every state except IDLE
//   grant_id         current / last granted requester
//   timeout_count    saturating count of timed-out commands
// -----------------------------------------------------------------------------
module debug_cmd_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int TIMEOUT      = 16,
  parameter int MAX_RESP_LEN = 16,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ*8-1:0] req_cmd,
  input  logic [NUM_REQ-1:0]   req_cmd_valid,
  output logic [NUM_REQ-1:0]   req_cmd_ready,
  output logic [7:0]           req_resp_data,
  output logic [NUM_REQ-1:0]   req_resp_valid,
  output logic                 req_resp_last,
  output logic [7:0]           debug_cmd,
  output logic                 debug_cmd_valid,
  input  logic [7:0]           debug_resp,
  input  logic                 debug_resp_valid,
  output logic                 busy,
  output logic [1:0]           grant_id,
  output logic [7:0]           timeout_count
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LW = $clog2(MAX_RESP_LEN) + 1;
  localparam int GW = ($clog2(GAP_CYCLES + 1) > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LEN_MAX    = LW'(MAX_RESP_LEN);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES);
  localparam logic [1:0]    RR_INIT    = 2'(NUM_REQ - 1);

`ifdef DEBUG_ARB_FIXED_PRIO_EN
  localparam int RR_FIRST = 1;  // requester 0 is handled outside the rotation
`else
  localparam int RR_FIRST = 0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_FIRST,
    STREAM,
    DRAIN,
    GAP
  } state_t;

  state_t               state_reg;
  logic [1:0]           rr_ptr_reg;
  logic [1:0]           grant_id_reg;
  logic [7:0]           debug_cmd_reg;
  logic                 debug_cmd_valid_reg;
  logic [7:0]           hold_reg;
  logic [LW-1:0]        len_reg;
  logic [TW-1:0]        timer_reg;
  logic [GW-1:0]        gap_cnt_reg;
  logic [7:0]           timeout_count_reg;
  logic [7:0]           resp_data_reg;
  logic [NUM_REQ-1:0]   resp_valid_reg;
  logic                 resp_last_reg;

  logic [1:0]           win;
  logic                 any_valid;
  logic [7:0]           cmd_sel;
  logic [NUM_REQ-1:0]   win_oh;
  logic [NUM_REQ-1:0]   grant_oh;

  // Round-robin pick: the valid requester with the smallest forward distance
  // from rr_ptr+1 (mod NUM_REQ) wins.
  always_comb begin
    int d;
    int best;
    win       = '0;
    any_valid = 1'b0;
    d         = 0;
    best      = NUM_REQ;
    for (int i = RR_FIRST; i < NUM_REQ; i++) begin
      d = i - int'(rr_ptr_reg) - 1;
      if (d < 0) begin
        d = d + NUM_REQ;
      end
      if (req_cmd_valid[i] && (d < best)) begin
        best      = d;
        win       = 2'(i);
        any_valid = 1'b1;
      end
    end
`ifdef DEBUG_ARB_FIXED_PRIO_EN
    if (req_cmd_valid[0]) begin
      win       = 2'd0;
      any_valid = 1'b1;
    end
`endif
  end

  always_comb begin
    cmd_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == 2'(i)) begin
        cmd_sel = req_cmd[8*i +: 8];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign win_oh[gi]   = (win == 2'(gi));
      assign grant_oh[gi] = (grant_id_reg == 2'(gi));
    end
  endgenerate

  // Ready is the only combinational output: the accept must coincide with the
  // requester's valid while the arbiter is still in IDLE.
  assign req_cmd_ready = (rst_n && (state_reg == IDLE) && any_valid) ? win_oh : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg           <= IDLE;
      rr_ptr_reg          <= RR_INIT;
      grant_id_reg        <= '0;
      debug_cmd_reg       <= '0;
      debug_cmd_valid_reg <= 1'b0;
      hold_reg            <= '0;
      len_reg             <= '0;
      timer_reg           <= '0;
      gap_cnt_reg         <= '0;
      timeout_count_reg   <= '0;
      resp_data_reg       <= '0;
      resp_valid_reg      <= '0;
      resp_last_reg       <= 1'b0;
    end else begin
      debug_cmd_valid_reg <= 1'b0;
      resp_valid_reg      <= '0;
      resp_last_reg       <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            debug_cmd_reg       <= cmd_sel;
            debug_cmd_valid_reg <= 1'b1;   // visible during the ISSUE cycle
            grant_id_reg        <= win;
`ifdef DEBUG_ARB_FIXED_PRIO_EN
            if (win != 2'd0) begin
              rr_ptr_reg <= win;
            end
`else
            rr_ptr_reg <= win;
`endif
            state_reg <= ISSUE;
          end
        end

        ISSUE: begin
          timer_reg <= '0;
          state_reg <= WAIT_FIRST;
        end

        WAIT_FIRST: begin
          if (debug_resp_valid) begin
            hold_reg  <= debug_resp;
            len_reg   <= LW'(1);
            state_reg <= STREAM;
          end else if (timer_reg == TIMER_LAST) begin
            resp_data_reg  <= 8'hFE;
            resp_valid_reg <= grant_oh;
            resp_last_reg  <= 1'b1;
            if (timeout_count_reg != 8'hFF) begin
              timeout_count_reg <= timeout_count_reg + 8'd1;
            end
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end

        // Every STREAM cycle forwards the held byte; whether it is the last
        // one depends on what the interface presents in the same cycle.
        STREAM: begin
          resp_data_reg  <= hold_reg;
          resp_valid_reg <= grant_oh;
          if (debug_resp_valid) begin
            if (len_reg < LEN_MAX) begin
              hold_reg <= debug_resp;
              len_reg  <= len_reg + LW'(1);
            end else begin
              resp_last_reg <= 1'b1;
              state_reg     <= DRAIN;
            end
          end else begin
            resp_last_reg <= 1'b1;
            gap_cnt_reg   <= '0;
            state_reg     <= GAP;
          end
        end

        DRAIN: begin
          if (!debug_resp_valid) begin
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end
        end

        // The first GAP cycle carries the registered final byte; GAP_CYCLES
        // fully idle cycles follow before the next arbitration.
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GW'(1);
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_resp_data   = resp_data_reg;
  assign req_resp_valid  = resp_valid_reg;
  assign req_resp_last   = resp_last_reg;
  assign debug_cmd       = debug_cmd_reg;
  assign debug_cmd_valid = debug_cmd_valid_reg;
  assign busy            = (state_reg != IDLE);
  assign grant_id        = grant_id_reg;
  assign timeout_count   = timeout_count_reg;

endmodule

// File: tb/tb_debug_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_debug_cmd_arbiter
//
// Directed bench for debug_cmd_arbiter. The initial block plays both the
// requesters and a stub debug_interface; expected response bytes are pushed
// to a scoreboard queue when stimulus is driven and a negedge monitor pops
// and compares them as the DUT emits them. Honours DEBUG_ARB_FIXED_PRIO_EN
// for the expected grant order.
// -----------------------------------------------------------------------------
module tb_debug_cmd_arbiter;

  localparam int NUM_REQ      = 2;
  localparam int TIMEOUT      = 16;
  localparam int MAX_RESP_LEN = 16;
  localparam int GAP_CYCLES   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ*8-1:0] req_cmd;
  logic [NUM_REQ-1:0]   req_cmd_valid;
  logic [NUM_REQ-1:0]   req_cmd_ready;
  logic [7:0]           req_resp_data;
  logic [NUM_REQ-1:0]   req_resp_valid;
  logic                 req_resp_last;
  logic [7:0]           debug_cmd;
  logic                 debug_cmd_valid;
  logic [7:0]           debug_resp;
  logic                 debug_resp_valid;
  logic                 busy;
  logic [1:0]           grant_id;
  logic [7:0]           timeout_count;

  debug_cmd_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT     (TIMEOUT),
    .MAX_RESP_LEN(MAX_RESP_LEN),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_cmd         (req_cmd),
    .req_cmd_valid   (req_cmd_valid),
    .req_cmd_ready   (req_cmd_ready),
    .req_resp_data   (req_resp_data),
    .req_resp_valid  (req_resp_valid),
    .req_resp_last   (req_resp_last),
    .debug_cmd       (debug_cmd),
    .debug_cmd_valid (debug_cmd_valid),
    .debug_resp      (debug_resp),
    .debug_resp_valid(debug_resp_valid),
    .busy            (busy),
    .grant_id        (grant_id),
    .timeout_count   (timeout_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int cmd_cyc = 0;
  int last_resp_cyc = 0;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] resp_bytes[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic [7:0] d, input logic l);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Response monitor / scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (req_resp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'(req_resp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_valid", 32'(req_resp_valid), 32'(1) << e.idx);
        check("resp_data", 32'(req_resp_data), 32'(e.data));
        check("resp_last", 32'(req_resp_last), 32'(e.last));
        $display("[TB] resp req%0d data=%02h last=%0b", e.idx, req_resp_data, req_resp_last);
      end
      if (req_resp_last) last_resp_cyc = cyc;
    end
  end

  task automatic wait_ready(output int w);
    w = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_cmd_ready != '0) begin
        check("ready_onehot", 32'($countones(req_cmd_ready)), 32'd1);
        for (int j = 0; j < NUM_REQ; j++) begin
          if (req_cmd_ready[j]) w = j;
        end
        break;
      end
    end
    check("ready_seen", 32'(w >= 0), 32'd1);
  endtask

  task automatic wait_cmd(input logic [7:0] cmd, input int gid);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (debug_cmd_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("cmd_seen", 32'(found), 32'd1);
    if (found) begin
      check("debug_cmd", 32'(debug_cmd), 32'(cmd));
      check("grant_id", 32'(grant_id), 32'(gid));
      cmd_cyc = cyc;
      $display("[TB] cmd req%0d byte=%02h", gid, debug_cmd);
    end
  endtask

  task automatic wait_idle();
    logic found;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) begin
        found = 1'b1;
        break;
      end
    end
    check("idle_reached", 32'(found), 32'd1);
  endtask

  // Requester i raises valid, is accepted, drops valid, then the command
  // strobe is checked in the following ISSUE cycle.
  task automatic request(input int i, input logic [7:0] cmd);
    int w;
    @(posedge clk); #1;
    req_cmd[8*i +: 8] = cmd;
    req_cmd_valid[i]  = 1'b1;
    wait_ready(w);
    check("grant_win", 32'(w), 32'(i));
    @(posedge clk); #1;
    req_cmd_valid[i] = 1'b0;
    wait_cmd(cmd, i);
  endtask

  // Stub interface: resp_bytes on consecutive cycles starting in WAIT_FIRST.
  task automatic drive_resp();
    foreach (resp_bytes[k]) begin
      @(posedge clk); #1;
      debug_resp       = resp_bytes[k];
      debug_resp_valid = 1'b1;
    end
    @(posedge clk); #1;
    debug_resp_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int exp_w;
    logic [7:0] cmd_w;

    rst_n            = 1'b0;
    req_cmd          = '0;
    req_cmd_valid    = '1;   // requests during reset must not be accepted
    debug_resp       = '0;
    debug_resp_valid = 1'b0;

    // ---- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_timeout_count", 32'(timeout_count), 32'd0);
    check("rst_resp_valid", 32'(req_resp_valid), 32'd0);
    check("rst_resp_last", 32'(req_resp_last), 32'd0);
    check("rst_resp_data", 32'(req_resp_data), 32'd0);
    check("rst_cmd_valid", 32'(debug_cmd_valid), 32'd0);
    check("rst_debug_cmd", 32'(debug_cmd), 32'd0);
    check("rst_ready", 32'(req_cmd_ready), 32'd0);
    @(posedge clk); #1;
    req_cmd_valid = '0;
    rst_n         = 1'b1;

    // ---- req0 and req1 together: req0 first, then req1 after the gap
    @(posedge clk); #1;
    req_cmd       = {8'h55, 8'hF0};
    req_cmd_valid = 2'b11;
    wait_ready(w);
    check("dual_first_win", 32'(w), 32'd0);
    @(posedge clk); #1;
    req_cmd_valid[0] = 1'b0;
    wait_cmd(8'hF0, 0);
    push_exp(0, 8'hF0, 1'b0);
    push_exp(0, 8'h01, 1'b0);
    push_exp(0, 8'h00, 1'b0);
    push_exp(0, 8'h00, 1'b1);
    resp_bytes = '{8'hF0, 8'h01, 8'h00, 8'h00};
    drive_resp();
    wait_ready(w);
    check("dual_second_win", 32'(w), 32'd1);
    @(posedge clk); #1;
    req_cmd_valid[1] = 1'b0;
    wait_cmd(8'h55, 1);
    check("gap_spacing", 32'((cmd_cyc - last_resp_cyc) >= GAP_CYCLES + 2), 32'd1);
    push_exp(1, 8'hAA, 1'b0);
    push_exp(1, 8'hBB, 1'b1);
    resp_bytes = '{8'hAA, 8'hBB};
    drive_resp();
    wait_idle();
    check("dual_sb_empty", 32'(exp_q.size()), 32'd0);

    // ---- both held valid: rr_ptr is 1 after req1, so round robin gives
    // 0,1,0,1; fixed priority gives 0 every round
    @(posedge clk); #1;
    req_cmd       = {8'hB1, 8'hA0};
    req_cmd_valid = 2'b11;
    for (int r = 0; r < 4; r++) begin
`ifdef DEBUG_ARB_FIXED_PRIO_EN
      exp_w = 0;
`else
      exp_w = r % 2;
`endif
      wait_ready(w);
      check("rr_win", 32'(w), 32'(exp_w));
      @(posedge clk); #1;
      if (r == 3) req_cmd_valid = '0;
      cmd_w = (exp_w == 0) ? 8'hA0 : 8'hB1;
      wait_cmd(cmd_w, exp_w);
      push_exp(exp_w, 8'(8'h10 + r), 1'b1);
      resp_bytes = '{8'(8'h10 + r)};
      drive_resp();
    end
    wait_idle();
    check("rr_sb_empty", 32'(exp_q.size()), 32'd0);

    // ---- 20 back-to-back bytes: only 00..0F forwarded, last on 0F
    request(0, 8'h13);
    resp_bytes = {};
    for (int b = 0; b < 20; b++) begin
      resp_bytes.push_back(8'(b));
      if (b < MAX_RESP_LEN) push_exp(0, 8'(b), b == MAX_RESP_LEN - 1);
    end
    drive_resp();
    wait_idle();
    check("trunc_sb_empty", 32'(exp_q.size()), 32'd0);

    // ---- silent interface: 16 waiting cycles, the FE byte is registered
    // out one cycle later
    request(1, 8'h77);
    push_exp(1, 8'hFE, 1'b1);
    wait_idle();
    check("timeout_latency", 32'(last_resp_cyc - cmd_cyc), 32'(TIMEOUT + 1));
    check("timeout_count_1", 32'(timeout_count), 32'd1);
    for (int t = 1; t < 256; t++) begin
      request(0, 8'h77);
      push_exp(0, 8'hFE, 1'b1);
      wait_idle();
    end
    check("timeout_count_sat", 32'(timeout_count), 32'hFF);
    check("timeout_sb_empty", 32'(exp_q.size()), 32'd0);

    // ---- reset for one cycle during STREAM after two delivered bytes
    request(0, 8'h31);
    push_exp(0, 8'hC1, 1'b0);
    push_exp(0, 8'hC2, 1'b0);
    @(posedge clk); #1;
    debug_resp = 8'hC1; debug_resp_valid = 1'b1;
    @(posedge clk); #1;
    debug_resp = 8'hC2;
    @(posedge clk); #1;
    debug_resp = 8'hC3;
    @(posedge clk); #1;
    debug_resp = 8'hC4;
    rst_n      = 1'b0;
    @(posedge clk); #1;
    debug_resp = 8'hC5;
    rst_n      = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_resp_valid", 32'(req_resp_valid), 32'd0);
    check("midrst_timeout_count", 32'(timeout_count), 32'd0);
    @(posedge clk); #1;
    debug_resp_valid = 1'b0;
    @(negedge clk);
    check("midrst_sb_empty", 32'(exp_q.size()), 32'd0);

    // ---- normal command after the mid-operation reset
    request(0, 8'h42);
    push_exp(0, 8'h11, 1'b0);
    push_exp(0, 8'h22, 1'b0);
    push_exp(0, 8'h33, 1'b1);
    resp_bytes = '{8'h11, 8'h22, 8'h33};
    drive_resp();
    wait_idle();
    check("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
